// File: rtl/mac_accum_norm.sv
// Product accumulator with round-to-2^-SHIFT, saturation to OUT_W and valid/ready result.
// Define MAC_CONVERGENT_ROUND_EN for round-half-to-even; default build rounds half up.
module mac_accum_norm #(
   parameter int unsigned IN_W  = 49,
   parameter int unsigned ACC_W = 56,
   parameter int unsigned OUT_W = 25,
   parameter int unsigned SHIFT = 24,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic [CNT_W-1:0] term_cnt
);

   localparam int unsigned EXT_W = ACC_W + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [EXT_W-1:0] HALF    = EXT_W'(1) << (SHIFT - 1);
   localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
   localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_term_cnt;
   logic               r_out_valid;
   logic [OUT_W-1:0]   r_out_data;
   logic               r_out_sat;

   logic               w_accept;
   logic               w_release;
   logic               w_term_last;
   logic [EXT_W-1:0]   w_acc_ext;
   logic [EXT_W-1:0]   w_sum;
   logic               w_add_ovf;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [EXT_W-1:0]   w_rnd_sum;
   logic signed [EXT_W-1:0] w_r;
   logic               w_clip_hi;
   logic               w_clip_lo;
   logic [OUT_W-1:0]   w_res;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ACCUM;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_accept && (in_last || w_term_last)) w_state_nxt = ROUND;
         ROUND:   w_state_nxt = HOLD;
         HOLD:    if (w_release) w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   // Output decode from registered state
   always_comb begin
      in_ready  = 1'b0;
      w_accept  = 1'b0;
      w_release = 1'b0;
      if (r_state == ACCUM) begin
         in_ready = 1'b1;
         w_accept = in_valid;
      end
      if (r_state == HOLD) w_release = r_out_valid & out_ready;
   end

   assign w_term_last = (r_term_cnt == {CNT_W{1'b1}});

   // Saturating accumulate, one guard bit detects signed overflow
   assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
   assign w_sum     = w_acc_ext + {{(EXT_W-IN_W){in_data[IN_W-1]}}, in_data};
   assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
   assign w_acc_nxt = w_add_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

   // Rounding and clip to the output word
   assign w_rnd_sum = w_acc_ext + HALF;
   always_comb begin
      w_r = $signed(w_rnd_sum) >>> SHIFT;
`ifdef MAC_CONVERGENT_ROUND_EN
      // Exact tie with an even quotient: truncate instead of rounding up
      if ((r_acc[SHIFT-1:0] == HALF[SHIFT-1:0]) && !r_acc[SHIFT])
         w_r = $signed(w_acc_ext) >>> SHIFT;
`endif
   end

   assign w_clip_hi = (w_r > OUT_MAX);
   assign w_clip_lo = (w_r < OUT_MIN);
   assign w_res     = w_clip_hi ? OUT_MAX[OUT_W-1:0] :
                      w_clip_lo ? OUT_MIN[OUT_W-1:0] : w_r[OUT_W-1:0];

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_term_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_acc      <= w_acc_nxt;
            r_ovf      <= r_ovf | w_add_ovf;
            r_term_cnt <= r_term_cnt + CNT_W'(1);
         end
         if (r_state == ROUND) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_sat   <= w_clip_hi | w_clip_lo | r_ovf;
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_term_cnt  <= '0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_mac_accum_norm.sv
// Directed bench for mac_accum_norm; expected values hand-computed from the 2^-24 scaling.
module tb_mac_accum_norm;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [48:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_data;
   logic        out_sat;
   logic [5:0]  term_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [24:0] held_data;

   mac_accum_norm dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .term_cnt  (term_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one term for a single edge; the block is in ACCUM when called
   task automatic send(input logic [48:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_term_cnt",  64'(term_cnt),  64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_sat",   64'(out_sat),   64'd0);
      reset = 1'b0;
      tick();
      chk("rst_in_ready",  64'(in_ready),  64'd1);

      // 1: single term, latency
      send(49'h300_0000, 1'b1);
      chk("t1_valid_at_N", 64'(out_valid), 64'd0);
      chk("t1_in_ready",   64'(in_ready),  64'd0);
      chk("t1_cnt",        64'(term_cnt),  64'd1);
      tick();
      chk("t1_valid_N1",   64'(out_valid), 64'd1);
      chk("t1_data",       64'(out_data),  64'd3);
      chk("t1_sat",        64'(out_sat),   64'd0);
      release_out();
      chk("t1_rel_valid",  64'(out_valid), 64'd0);
      chk("t1_rel_ready",  64'(in_ready),  64'd1);
      chk("t1_rel_cnt",    64'(term_cnt),  64'd0);

      // 2: tie at 2.5 -> 3 half-up, 2 convergent
      send(49'h100_0000, 1'b0);
      send(49'h200_0000, 1'b0);
      send(49'(-64'sh80_0000), 1'b1);
      tick();
      chk("t2_cnt",        64'(term_cnt),  64'd3);
`ifdef MAC_CONVERGENT_ROUND_EN
      chk("t2_data",       64'(out_data),  64'd2);
`else
      chk("t2_data",       64'(out_data),  64'd3);
`endif
      chk("t2_sat",        64'(out_sat),   64'd0);
      release_out();

      // 3: positive clip, then exact most-negative value
      send(49'h0_FFFF_FFFF_FFFF, 1'b0);
      send(49'h0_FFFF_FFFF_FFFF, 1'b1);
      tick();
      chk("t3_pos_data",   64'(out_data),  64'h0FF_FFFF);
      chk("t3_pos_sat",    64'(out_sat),   64'd1);
      release_out();
      send(49'h1_0000_0000_0000, 1'b1);
      tick();
      chk("t3_neg_data",   64'(out_data),  64'h100_0000);
      chk("t3_neg_sat",    64'(out_sat),   64'd0);

      // 4: backpressure in HOLD with upstream pushing
      held_data = out_data;
      in_valid = 1'b1; in_data = 49'h700_0000; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_in_ready", 64'(in_ready),  64'd0);
         chk("t4_valid",    64'(out_valid), 64'd1);
         chk("t4_data",     64'(out_data),  64'(held_data));
         chk("t4_cnt",      64'(term_cnt),  64'd1);
      end
      release_out();
      in_valid = 1'b0; in_last = 1'b0;
      chk("t4_rel_ready",  64'(in_ready),  64'd1);
      chk("t4_rel_cnt",    64'(term_cnt),  64'd0);
      tick();
      chk("t4_no_absorb",  64'(term_cnt),  64'd0);

      // 5: 64 terms without in_last force ROUND and wrap the counter
      in_valid = 1'b1; in_data = 49'h100_0000; in_last = 1'b0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (i == 31) chk("t5_mid_cnt", 64'(term_cnt), 64'd32);
      end
      in_valid = 1'b0;
      chk("t5_wrap_cnt",   64'(term_cnt),  64'd0);
      chk("t5_in_ready",   64'(in_ready),  64'd0);
      tick();
      chk("t5_valid",      64'(out_valid), 64'd1);
      chk("t5_data",       64'(out_data),  64'd64);
      chk("t5_sat",        64'(out_sat),   64'd0);

      // 6: async reset during HOLD, then mid-ACCUM
      #2 reset = 1'b1;
      #1;
      chk("t6_hold_valid", 64'(out_valid), 64'd0);
      chk("t6_hold_cnt",   64'(term_cnt),  64'd0);
      tick();
      reset = 1'b0;
      send(49'h100_0000, 1'b0);
      send(49'h100_0000, 1'b0);
      chk("t6_acc_cnt",    64'(term_cnt),  64'd2);
      #2 reset = 1'b1;
      #1;
      chk("t6_mid_cnt",    64'(term_cnt),  64'd0);
      chk("t6_mid_valid",  64'(out_valid), 64'd0);
      tick();
      reset = 1'b0;
      in_last = 1'b1;
      tick();
      in_last = 1'b0;
      chk("t6_last_only",  64'(term_cnt),  64'd0);
      chk("t6_last_ready", 64'(in_ready),  64'd1);
      send(49'h100_0000, 1'b1);
      tick();
      chk("t6_data",       64'(out_data),  64'd1);
      chk("t6_valid",      64'(out_valid), 64'd1);
      release_out();
      chk("t6_rel_valid",  64'(out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
